// File: rtl/bolme_pkg.sv
// bolme_pkg: shared state encoding and default operand width for the divider.
package bolme_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bolme_step.sv
// bolme_step: one combinational restoring-division step on a WIDTH+1-bit trial value.
module bolme_step
  import bolme_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] t;
  logic [WIDTH:0] d;
  logic ge;
  always_comb begin
    t = {r, q[WIDTH-1]};
    d = {1'b0, divisor};
    ge = t >= d;
    r_next = ge ? WIDTH'(t - d) : t[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/bolme.sv
// bolme: sequential restoring divider, one quotient bit per clock, start/done handshake.
module bolme
  import bolme_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] r, q, dvs, dvd, r_next, q_next;
  logic accept, zero;
  bolme_step #(.WIDTH(WIDTH)) u_step (
    .r(r),
    .q(q),
    .divisor(dvs),
    .r_next(r_next),
    .q_next(q_next)
  );
  // the done cycle still counts as busy, so a start seen during it is dropped
  assign accept = state == S_IDLE && start && !done;
  assign busy = state != S_IDLE || done;
  assign zero = dvs == '0;
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE ? (accept ? (divisor == '0 ? S_DONE : S_CALC) : S_IDLE) :
              state == S_CALC ? (cnt == '0 ? S_DONE : S_CALC) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      r <= '0;
      q <= '0;
      dvs <= '0;
      dvd <= '0;
      quotient <= '0;
      remainder <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd <= dividend;
        dvs <= divisor;
        r <= '0;
        q <= dividend;
        cnt <= CW'(WIDTH - 1);
        div_zero <= 1'b0;
      end else if (state == S_CALC) begin
        r <= r_next;
        q <= q_next;
        cnt <= cnt - 1'b1;
      end else if (state == S_DONE) begin
        quotient <= zero ? '1 : q;
        remainder <= zero ? dvd : r;
        div_zero <= zero;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bolme.sv
// tb_bolme: directed checks of the divider at WIDTH=4 and WIDTH=8.
module tb_bolme;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0, quotient, remainder;
  logic done, busy, div_zero;
  logic start8 = 1'b0;
  logic [7:0] dividend8 = '0, divisor8 = '0, quotient8, remainder8;
  logic done8, busy8, div_zero8;
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  bolme #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy), .div_zero(div_zero)
  );
  bolme #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .quotient(quotient8), .remainder(remainder8), .done(done8), .busy(busy8), .div_zero(div_zero8)
  );

  // called 1 time unit after a rising edge; returns edges from accept to done, -1 on timeout
  task automatic launch4(input logic [3:0] a, input logic [3:0] b, output int lat);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if ({quotient, remainder, done, busy, div_zero} !== 11'b0)
      $display("FAIL reset: got q=%0d r=%0d done=%b busy=%b dz=%b, want all 0", quotient, remainder, done, busy, div_zero);
    else pass_cnt++;
  endtask

  task automatic test_divide(input string name, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] eq, input logic [3:0] er, input logic ez, input int elat);
    int lat;
    launch4(a, b, lat);
    total++;
    if (lat !== elat) $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
    else pass_cnt++;
    total++;
    if ({quotient, remainder, div_zero} !== {eq, er, ez})
      $display("FAIL %s result: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b", name, quotient, remainder, div_zero, eq, er, ez);
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || {quotient, remainder, div_zero} !== {eq, er, ez})
      $display("FAIL %s hold: got done=%b busy=%b q=%0d r=%0d want done=0 busy=0 held results", name, done, busy, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_mid_start;
    int lat;
    dividend = 4'd14;
    divisor = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) $display("FAIL mid_start busy: got %b want 1", busy);
    else pass_cnt++;
    dividend = 4'd15;
    divisor = 4'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 3; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== 5 || quotient !== 4'd4 || remainder !== 4'd2)
      $display("FAIL mid_start: got lat=%0d q=%0d r=%0d want lat=5 q=4 r=2", lat, quotient, remainder);
    else pass_cnt++;
    repeat (8) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL mid_start queued: got done=%b busy=%b want 0 0", done, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    dividend = 4'd13;
    divisor = 4'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    total++;
    if (seen || {quotient, remainder, busy, div_zero} !== 10'b0)
      $display("FAIL reset_mid: got done_seen=%b q=%0d r=%0d busy=%b dz=%b want none and 0", seen, quotient, remainder, busy, div_zero);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    launch4(4'd7, 4'd2, lat);
    dividend = 4'd12;
    divisor = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd1)
      $display("FAIL b2b ignored: got busy=%b done=%b q=%0d r=%0d want 0 0 3 1", busy, done, quotient, remainder);
    else pass_cnt++;
    launch4(4'd12, 4'd5, lat);
    total++;
    if (lat !== 5 || quotient !== 4'd2 || remainder !== 4'd2)
      $display("FAIL b2b second: got lat=%0d q=%0d r=%0d want 5 2 2", lat, quotient, remainder);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_wide;
    int lat = -1;
    dividend8 = 8'd154;
    divisor8 = 8'd11;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    total++;
    if (busy8 !== 1'b1) $display("FAIL wide busy: got %b want 1", busy8);
    else pass_cnt++;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== 9 || quotient8 !== 8'd14 || remainder8 !== 8'd0 || div_zero8 !== 1'b0)
      $display("FAIL wide: got lat=%0d q=%0d r=%0d dz=%b want 9 14 0 0", lat, quotient8, remainder8, div_zero8);
    else pass_cnt++;
  endtask

  initial begin
    #1;
    test_reset;
    test_divide("basic", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 5);
    test_divide("small", 4'd11, 4'd14, 4'd0, 4'd11, 1'b0, 5);
    test_divide("unit", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
    test_divide("divzero", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
    test_divide("after_zero", 4'd10, 4'd4, 4'd2, 4'd2, 1'b0, 5);
    test_mid_start;
    test_reset_mid;
    test_back_to_back;
    test_wide;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
